// File: rtl/est_pkg.sv
// Shared encodings and the flat-frame element offset helper for the estimation
// sample streamer.
package est_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Bit offset of element (source d, sample n) inside a flat frame.
    function automatic int unsigned elem_off(input int unsigned d, input int unsigned n,
                                             input int unsigned samples,
                                             input int unsigned data_width);
        return (d * samples + n) * data_width;
    endfunction

endpackage

// File: rtl/est_frame_bank.sv
// One captured estimation frame plus a column mux that presents all DIM
// sources of a selected sample as a single output beat.
module est_frame_bank
    import est_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DIM        = 3,
    parameter  int SAMPLES    = 4,
    localparam int IDX_W      = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
    input  logic                                 clk,
    input  logic                                 load,
    input  logic [0:DATA_WIDTH*DIM*SAMPLES-1]    frame,
    input  logic [IDX_W-1:0]                     idx,
    output logic [DATA_WIDTH*DIM-1:0]            col
);

    logic [0:DATA_WIDTH*DIM*SAMPLES-1] frame_q;

    always_ff @(posedge clk) begin
        if (load) begin
            frame_q <= frame;
        end
    end

    for (genvar d = 0; d < DIM; d++) begin : g_col
        assign col[d*DATA_WIDTH +: DATA_WIDTH] =
            frame_q[elem_off(d, 32'(idx), SAMPLES, DATA_WIDTH) +: DATA_WIDTH];
    end

endmodule

// File: rtl/est_sample_streamer.sv
// Captures each estimation frame into one of two banks and replays it as
// per-sample DIM-component beats over a valid/ready stream.
module est_sample_streamer
    import est_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DIM        = 3,
    parameter  int SAMPLES    = 4,
    localparam int IDX_W      = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 est_opvld,
    input  logic [0:DATA_WIDTH*DIM*SAMPLES-1]    s_est_in,
    output logic                                 in_ready,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DATA_WIDTH*DIM-1:0]            m_data,
    output logic [IDX_W-1:0]                     m_idx,
    output logic                                 m_last,
    output logic [15:0]                          frame_cnt,
    output logic                                 overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                      est_prev;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                occ;
    logic [1:0]                occ_next;
    state_t                    state;
    logic                      cap;
    logic                      hs;
    logic                      rel;
    logic                      accept;
    logic [IDX_W-1:0]          idx_inc;
    logic [DATA_WIDTH*DIM-1:0] col [2];

    assign cap     = est_opvld && !est_prev;
    assign hs      = m_valid && m_ready;
    assign rel     = hs && m_last;
    // A full buffer still takes a frame when the head frame leaves on this edge.
    assign accept  = cap && ((occ != OCC_FULL) || rel);
    assign idx_inc = m_idx + IDX_ONE;

    always_comb begin
        occ_next = occ;
        if (accept && !rel) begin
            occ_next = occ + 2'd1;
        end else if (!accept && rel) begin
            occ_next = occ - 2'd1;
        end
    end

    assign in_ready = (occ != OCC_FULL);
    assign m_data   = m_valid ? col[rd_ptr] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        est_frame_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DIM        (DIM),
            .SAMPLES    (SAMPLES)
        ) u_bank (
            .clk   (clk),
            .load  (accept && (wr_ptr == 1'(b))),
            .frame (s_est_in),
            .idx   (m_idx),
            .col   (col[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            est_prev  <= 1'b1;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= OCC_EMPTY;
            overflow  <= 1'b0;
            frame_cnt <= 16'd0;
            state     <= ST_IDLE;
            m_valid   <= 1'b0;
            m_idx     <= '0;
            m_last    <= 1'b0;
        end else begin
            est_prev <= est_opvld;
            occ      <= occ_next;
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rel) begin
                rd_ptr    <= ~rd_ptr;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (cap && !accept) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (occ != OCC_EMPTY) begin
                        state   <= ST_STREAM;
                        m_valid <= 1'b1;
                        m_idx   <= '0;
                        m_last  <= (LAST_IDX == '0);
                    end
                end
                ST_STREAM: begin
                    if (hs) begin
                        if (!m_last) begin
                            m_idx  <= idx_inc;
                            m_last <= (idx_inc == LAST_IDX);
                        end else begin
                            m_idx <= '0;
                            // Chain straight into the other bank when it holds a frame.
                            if (occ_next != OCC_EMPTY) begin
                                m_last <= (LAST_IDX == '0);
                            end else begin
                                state   <= ST_IDLE;
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_est_sample_streamer.sv
// Self-checking bench for est_sample_streamer: table-driven frames plus
// hand-written overflow, coincident-capture and reset sequences.
module tb_est_sample_streamer;

    localparam int DW    = 16;
    localparam int DIM   = 3;
    localparam int S     = 4;
    localparam int IDX_W = 2;
    localparam int FW    = DW * DIM * S;
    localparam int MW    = DW * DIM;

    typedef struct {
        logic [MW-1:0]    data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    typedef struct {
        logic [15:0] base;
        int          mode;
        int          exp_cnt;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              est_opvld;
    logic [0:FW-1]     s_est_in;
    logic              in_ready;
    logic              m_valid;
    logic              m_ready;
    logic [MW-1:0]     m_data;
    logic [IDX_W-1:0]  m_idx;
    logic              m_last;
    logic [15:0]       frame_cnt;
    logic              overflow;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ready_mode = 0;
    bit    mon_en = 1'b0;

    est_sample_streamer #(
        .DATA_WIDTH (DW),
        .DIM        (DIM),
        .SAMPLES    (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .est_opvld (est_opvld),
        .s_est_in  (s_est_in),
        .in_ready  (in_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .frame_cnt (frame_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:FW-1] make_frame(input logic [15:0] base);
        logic [0:FW-1] f;
        logic [15:0]   v;
        f = '0;
        for (int k = 0; k < DIM * S; k++) begin
            v = base + 16'(k);
            f[k*DW +: DW] = v;
        end
        return f;
    endfunction

    task automatic push_frame(input logic [15:0] base);
        beat_t b;
        for (int n = 0; n < S; n++) begin
            b.data = '0;
            for (int d = 0; d < DIM; d++) begin
                b.data[d*DW +: DW] = base + 16'(d * S + n);
            end
            b.idx  = IDX_W'(n);
            b.last = (n == S - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic capture(input logic [15:0] base, input bit expect_accept);
        @(posedge clk); #1;
        s_est_in  = make_frame(base);
        est_opvld = 1'b1;
        if (expect_accept) push_frame(base);
        @(posedge clk); #1;
        est_opvld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !m_valid) break;
        end
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
        check({name, "_valid_low"}, 64'(m_valid), 64'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    // Drives m_ready each cycle according to the current pattern.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: every valid beat must equal the head entry, popped on handshake.
    always @(negedge clk) begin
        if (mon_en && !rst && m_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h idx %0d, expected no beat", m_data, m_idx);
            end else begin
                check("beat_data", 64'(m_data), 64'(sb_q[0].data));
                check("beat_idx",  64'(m_idx),  64'(sb_q[0].idx));
                check("beat_last", 64'(m_last), 64'(sb_q[0].last));
                if (m_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   bubbles;
        int   seen;
        bit   found;

        vecs[0] = '{base: 16'h0100, mode: 0, exp_cnt: 1};
        vecs[1] = '{base: 16'h8000, mode: 1, exp_cnt: 2};
        vecs[2] = '{base: 16'hFFFE, mode: 2, exp_cnt: 3};
        vecs[3] = '{base: 16'h7FF8, mode: 0, exp_cnt: 4};

        rst       = 1'b1;
        est_opvld = 1'b0;
        s_est_in  = '0;
        reset_dut();
        mon_en = 1'b1;

        check("rst_m_valid",   64'(m_valid),   64'd0);
        check("rst_m_data",    64'(m_data),    64'd0);
        check("rst_m_idx",     64'(m_idx),     64'd0);
        check("rst_m_last",    64'(m_last),    64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        for (int i = 0; i < 4; i++) begin
            ready_mode = vecs[i].mode;
            capture(vecs[i].base, 1'b1);
            if (i == 0) begin
                found = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (m_valid) begin found = 1'b1; break; end
                end
                check("first_beat_seen", 64'(found), 64'd1);
                check("first_beat_data", 64'(m_data), 64'h0108_0104_0100);
            end
            wait_drain("vec");
            check("vec_frame_cnt", 64'(frame_cnt), 64'(vecs[i].exp_cnt));
            check("vec_overflow",  64'(overflow),  64'd0);
        end

        // Level held high: one frame only.
        ready_mode = 0;
        @(posedge clk); #1;
        s_est_in  = make_frame(16'h2000);
        est_opvld = 1'b1;
        push_frame(16'h2000);
        repeat (20) @(posedge clk);
        #1;
        est_opvld = 1'b0;
        wait_drain("held");
        check("held_frame_cnt", 64'(frame_cnt), 64'd5);
        check("held_overflow",  64'(overflow),  64'd0);

        // Stalled consumer: third frame dropped, then A and B back to back.
        ready_mode = 3;
        repeat (2) @(posedge clk);
        capture(16'h0A00, 1'b1);
        capture(16'h0B00, 1'b1);
        check("ovf_in_ready_full", 64'(in_ready), 64'd0);
        capture(16'h0C00, 1'b0);
        check("ovf_overflow_set", 64'(overflow), 64'd1);
        ready_mode = 0;
        bubbles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
            if (!m_valid) bubbles++;
        end
        check("ovf_no_bubble", 64'(bubbles), 64'd0);
        wait_drain("ovf");
        check("ovf_frame_cnt", 64'(frame_cnt), 64'd7);
        check("ovf_overflow_sticky", 64'(overflow), 64'd1);

        // Capture of C on the same edge as A's final beat while B is pending.
        reset_dut();
        ready_mode = 3;
        capture(16'h3000, 1'b1);
        capture(16'h3100, 1'b1);
        ready_mode = 0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid && m_last && m_ready) begin found = 1'b1; break; end
        end
        check("coin_found_last", 64'(found), 64'd1);
        s_est_in  = make_frame(16'h3200);
        est_opvld = 1'b1;
        push_frame(16'h3200);
        @(posedge clk); #1;
        est_opvld = 1'b0;
        check("coin_overflow", 64'(overflow), 64'd0);
        wait_drain("coin");
        check("coin_frame_cnt", 64'(frame_cnt), 64'd3);
        check("coin_overflow_end", 64'(overflow), 64'd0);

        // Reset during beat 2 with the estimator level high.
        reset_dut();
        ready_mode = 1;
        capture(16'h4000, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid && m_idx == 2'd2) begin found = 1'b1; break; end
        end
        check("mid_found_beat2", 64'(found), 64'd1);
        rst       = 1'b1;
        est_opvld = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check("mid_m_valid",   64'(m_valid),   64'd0);
        check("mid_m_data",    64'(m_data),    64'd0);
        check("mid_m_idx",     64'(m_idx),     64'd0);
        check("mid_m_last",    64'(m_last),    64'd0);
        check("mid_frame_cnt", 64'(frame_cnt), 64'd0);
        check("mid_overflow",  64'(overflow),  64'd0);
        check("mid_in_ready",  64'(in_ready),  64'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        check("mid_no_capture", 64'(seen), 64'd0);
        check("mid_in_ready_hold", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        est_opvld = 1'b0;
        capture(16'h4100, 1'b1);
        wait_drain("mid");
        check("mid_frame_cnt_after", 64'(frame_cnt), 64'd1);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
